// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay RAM controller and its clear sweep.
package overlay_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, DONE = 2'd2} state_t;

   localparam int ADDR_W  = 20;
   localparam int MARK_W  = 2;
   localparam int COORD_W = 10;

   localparam logic [MARK_W-1:0] MARK_NONE   = 2'b00;
   localparam logic [MARK_W-1:0] MARK_BRIGHT = 2'b11;

   // RAM address layout is {X, Y}.
   function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
      return {x, y};
   endfunction
endpackage

// File: rtl/overlay_ram_ctrl_if.sv
// Host handshake plus both RAM ports. master = controller side, slave = host/RAM side.
interface overlay_ram_ctrl_if;
   import overlay_pkg::*;

   logic                host_req;
   logic                host_we;
   logic [ADDR_W-1:0]   host_addr;
   logic [MARK_W-1:0]   host_wdata;
   logic                host_gnt;
   logic                host_rvalid;
   logic [MARK_W-1:0]   host_rdata;
   logic [ADDR_W-1:0]   ram_rdaddress;
   logic [ADDR_W-1:0]   ram_wraddress;
   logic [MARK_W-1:0]   ram_data;
   logic                ram_wren;
   logic [MARK_W-1:0]   ram_q;

   modport master (
      input  host_req, host_we, host_addr, host_wdata, ram_q,
      output host_gnt, host_rvalid, host_rdata,
             ram_rdaddress, ram_wraddress, ram_data, ram_wren
   );

   modport slave (
      output host_req, host_we, host_addr, host_wdata, ram_q,
      input  host_gnt, host_rvalid, host_rdata,
             ram_rdaddress, ram_wraddress, ram_data, ram_wren
   );
endinterface

// File: rtl/overlay_clear_sweep.sv
// X/Y sweep counter for the frame clear: Y inner, X outer, steps once per enabled cycle
// and wraps to {0,0} after the last pixel so the next clear starts clean.
module overlay_clear_sweep
   import overlay_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);

   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

   assign last = (x_q == X_MAX) && (y_q == Y_MAX);
   assign addr = pack_addr(x_q, y_q);

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (en) begin
         if (y_q == Y_MAX) begin
            y_d = '0;
            x_d = last ? '0 : x_q + COORD_W'(1);
         end else begin
            y_d = y_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end
endmodule

// File: rtl/overlay_ram_ctrl.sv
// Overlay RAM sequencer: raster reads, write-port arbitration (clear > mark > host write)
// and host reads in blanking. Every output is a flop.
module overlay_ram_ctrl
   import overlay_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int WR_LAG   = 4
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [COORD_W-1:0] VGA_X,
   input  logic [COORD_W-1:0] VGA_Y,
   input  logic               pix_valid,
   input  logic               run,
   input  logic               clear_req,
   input  logic               mark_en,
   input  logic [MARK_W-1:0]  mark_val,
   output logic               busy,
   output logic               clear_done,
   overlay_ram_ctrl_if.master bus
);
   state_t              state_q, state_d;
   logic                run_q;
   logic                busy_q, busy_d;
   logic                clear_done_q, clear_done_d;
   logic                host_gnt_q, host_gnt_d;
   logic [1:0]          rd_vld_q, rd_vld_d;
   logic                host_rvalid_q, host_rvalid_d;
   logic [MARK_W-1:0]   host_rdata_q, host_rdata_d;
   logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
   logic [ADDR_W-1:0]   wraddr_q, wraddr_d;
   logic [MARK_W-1:0]   wdata_q, wdata_d;
   logic                wren_q, wren_d;

   logic                clr_start, clr_act, sweep_last;
   logic                mark_ok, host_free, wr_gnt, rd_gnt;
   logic [ADDR_W-1:0]   sweep_addr;
   logic [COORD_W-1:0]  lag_x;

   // The request cycle itself issues write {0,0}, giving one cycle from request to first write.
   assign clr_start = (state_q == IDLE) && (clear_req || (run && !run_q));
   assign clr_act   = clr_start || (state_q == CLEAR);

   overlay_clear_sweep #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_sweep (
      .clk   (CLK),
      .rst_n (RESET_N),
      .en    (clr_act),
      .addr  (sweep_addr),
      .last  (sweep_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (clr_start) state_d = CLEAR;
         CLEAR:   if (sweep_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      lag_x     = VGA_X - COORD_W'(WR_LAG);
      mark_ok   = mark_en && pix_valid && (VGA_X >= COORD_W'(WR_LAG)) && !clr_act;
      // One transaction in flight: block the cycle after a grant and the whole read pipe.
      host_free = !clr_act && !host_gnt_q && (rd_vld_q == 2'b00);
      wr_gnt    = host_free && bus.host_req && bus.host_we && (!pix_valid || !mark_en);
      rd_gnt    = host_free && bus.host_req && !bus.host_we && !pix_valid;

      busy_d       = clr_act;
      clear_done_d = (state_q == DONE);
      host_gnt_d   = wr_gnt || rd_gnt;
      rd_vld_d     = {rd_vld_q[0], rd_gnt};

      wren_d   = clr_act || mark_ok || wr_gnt;
      wraddr_d = wraddr_q;
      wdata_d  = wdata_q;
      if (clr_act) begin
         wraddr_d = sweep_addr;
         wdata_d  = MARK_NONE;
      end else if (mark_ok) begin
         wraddr_d = pack_addr(lag_x, VGA_Y);
         wdata_d  = mark_val;
      end else if (wr_gnt) begin
         wraddr_d = bus.host_addr;
         wdata_d  = bus.host_wdata;
      end

      rdaddr_d = rdaddr_q;
      if (pix_valid)   rdaddr_d = pack_addr(VGA_X, VGA_Y);
      else if (rd_gnt) rdaddr_d = bus.host_addr;

      // ram_q is valid the cycle after the address; capture it then for t+2 delivery.
      host_rvalid_d = rd_vld_q[1];
      host_rdata_d  = rd_vld_q[1] ? bus.ram_q : host_rdata_q;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q       <= IDLE;
         run_q         <= 1'b0;
         busy_q        <= 1'b0;
         clear_done_q  <= 1'b0;
         host_gnt_q    <= 1'b0;
         rd_vld_q      <= 2'b00;
         host_rvalid_q <= 1'b0;
         host_rdata_q  <= '0;
         rdaddr_q      <= '0;
         wraddr_q      <= '0;
         wdata_q       <= '0;
         wren_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         run_q         <= run;
         busy_q        <= busy_d;
         clear_done_q  <= clear_done_d;
         host_gnt_q    <= host_gnt_d;
         rd_vld_q      <= rd_vld_d;
         host_rvalid_q <= host_rvalid_d;
         host_rdata_q  <= host_rdata_d;
         rdaddr_q      <= rdaddr_d;
         wraddr_q      <= wraddr_d;
         wdata_q       <= wdata_d;
         wren_q        <= wren_d;
      end
   end

   assign busy              = busy_q;
   assign clear_done        = clear_done_q;
   assign bus.host_gnt      = host_gnt_q;
   assign bus.host_rvalid   = host_rvalid_q;
   assign bus.host_rdata    = host_rdata_q;
   assign bus.ram_rdaddress = rdaddr_q;
   assign bus.ram_wraddress = wraddr_q;
   assign bus.ram_data      = wdata_q;
   assign bus.ram_wren      = wren_q;
endmodule

// File: tb/tb_overlay_ram_ctrl.sv
// Directed bench for overlay_ram_ctrl with a reduced 40x30 frame and a behavioural RAM.
module tb_overlay_ram_ctrl;
   import overlay_pkg::*;

   localparam int H = 40, V = 30, N = H * V, LAG = 4;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [9:0] VGA_X, VGA_Y;
   logic       pix_valid, run, clear_req, mark_en;
   logic [1:0] mark_val;
   logic       busy, clear_done;
   int         n_chk = 0;
   int         n_fail = 0;

   overlay_ram_ctrl_if bus();

   overlay_ram_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .WR_LAG(LAG)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .VGA_X      (VGA_X),
      .VGA_Y      (VGA_Y),
      .pix_valid  (pix_valid),
      .run        (run),
      .clear_req  (clear_req),
      .mark_en    (mark_en),
      .mark_val   (mark_val),
      .busy       (busy),
      .clear_done (clear_done),
      .bus        (bus)
   );

   always #5 CLK = ~CLK;

   logic [1:0] mem [0:(1<<20)-1];
   always @(posedge CLK) begin
      if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
      bus.ram_q <= mem[bus.ram_rdaddress];
   end

   task automatic idle_inputs();
      VGA_X = 0; VGA_Y = 0; pix_valid = 0; run = 0; clear_req = 0;
      mark_en = 0; mark_val = 0;
      bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      idle_inputs();
      repeat (3) @(negedge CLK);
      n_chk++;
      if ({busy, clear_done, bus.host_gnt, bus.host_rvalid, bus.ram_wren} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 00000",
                  {busy, clear_done, bus.host_gnt, bus.host_rvalid, bus.ram_wren});
      end
      n_chk++;
      if ({bus.ram_rdaddress, bus.ram_wraddress, bus.ram_data, bus.host_rdata} !== 44'h0) begin
         n_fail++;
         $display("FAIL reset_buses got %h want 0",
                  {bus.ram_rdaddress, bus.ram_wraddress, bus.ram_data, bus.host_rdata});
      end
      RESET_N = 1'b1;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_clear_sweep();
      logic [9:0]  ex, ey;
      logic [19:0] last_a;
      int cnt, bad;
      ex = 0; ey = 0; cnt = 0; bad = 0; last_a = '1;
      @(negedge CLK) clear_req = 1;
      @(negedge CLK) clear_req = 0;
      while (busy === 1'b1 && cnt < N + 100) begin
         if (bus.ram_wren !== 1'b1 || bus.ram_data !== 2'b00 || bus.ram_wraddress !== {ex, ey})
            bad++;
         last_a = bus.ram_wraddress;
         cnt++;
         if (ey == 10'(V - 1)) begin ey = 0; ex++; end
         else ey++;
         @(negedge CLK);
      end
      n_chk++;
      if (cnt != N) begin n_fail++; $display("FAIL clear_busy_len got %0d want %0d", cnt, N); end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL clear_write_seq got %0d bad writes want 0", bad); end
      n_chk++;
      if (last_a !== {10'd39, 10'd29}) begin
         n_fail++; $display("FAIL clear_last_addr got %h want %h", last_a, {10'd39, 10'd29});
      end
      n_chk++;
      if (clear_done !== 1'b1 || bus.ram_wren !== 1'b0) begin
         n_fail++; $display("FAIL clear_done_pulse got done=%b wren=%b want 1 0", clear_done, bus.ram_wren);
      end
      @(negedge CLK);
      n_chk++;
      if (clear_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL clear_done_width got done=%b busy=%b want 0 0", clear_done, busy);
      end
   endtask

   task automatic test_mark_lag();
      @(negedge CLK);
      pix_valid = 1; VGA_X = 100; VGA_Y = 50; mark_en = 1; mark_val = 3;
      @(negedge CLK);
      n_chk++;
      if ({bus.ram_wren, bus.ram_wraddress, bus.ram_data} !== {1'b1, 10'd96, 10'd50, 2'd3}) begin
         n_fail++; $display("FAIL mark_lag got wren=%b addr=%h data=%0d want 1 %h 3",
                            bus.ram_wren, bus.ram_wraddress, bus.ram_data, {10'd96, 10'd50});
      end
      n_chk++;
      if (bus.ram_rdaddress !== {10'd100, 10'd50}) begin
         n_fail++; $display("FAIL raster_rdaddr got %h want %h", bus.ram_rdaddress, {10'd100, 10'd50});
      end
      VGA_X = 2;
      @(negedge CLK);
      n_chk++;
      if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL mark_x_lt_lag got wren=%b want 0", bus.ram_wren); end
      VGA_X = 4; mark_val = 2;
      @(negedge CLK);
      n_chk++;
      if ({bus.ram_wren, bus.ram_wraddress, bus.ram_data} !== {1'b1, 10'd0, 10'd50, 2'd2}) begin
         n_fail++; $display("FAIL mark_x_eq_lag got wren=%b addr=%h data=%0d want 1 %h 2",
                            bus.ram_wren, bus.ram_wraddress, bus.ram_data, {10'd0, 10'd50});
      end
      pix_valid = 0; VGA_X = 100;
      @(negedge CLK);
      n_chk++;
      if (bus.ram_wren !== 1'b0) begin n_fail++; $display("FAIL mark_blank got wren=%b want 0", bus.ram_wren); end
      idle_inputs();
   endtask

   task automatic test_host_active();
      int seen;
      seen = 0;
      @(negedge CLK);
      pix_valid = 1; VGA_X = 200; VGA_Y = 20; mark_en = 1; mark_val = 3;
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = {10'd300, 10'd20}; bus.host_wdata = 1;
      repeat (4) begin
         @(negedge CLK);
         if (bus.host_gnt === 1'b1) seen++;
      end
      n_chk++;
      if (seen != 0) begin n_fail++; $display("FAIL host_wr_vs_mark got %0d grants want 0", seen); end
      mark_en = 0;
      @(negedge CLK);
      n_chk++;
      if ({bus.host_gnt, bus.ram_wren, bus.ram_wraddress, bus.ram_data} !==
          {1'b1, 1'b1, 10'd300, 10'd20, 2'd1}) begin
         n_fail++; $display("FAIL host_wr_grant got gnt=%b wren=%b addr=%h data=%0d want 1 1 %h 1",
                            bus.host_gnt, bus.ram_wren, bus.ram_wraddress, bus.ram_data, {10'd300, 10'd20});
      end
      bus.host_req = 0;
      @(negedge CLK);
      n_chk++;
      if (bus.host_gnt !== 1'b0) begin n_fail++; $display("FAIL host_gnt_pulse got %b want 0", bus.host_gnt); end
      idle_inputs();
   endtask

   task automatic test_host_read();
      int seen;
      seen = 0;
      @(negedge CLK);
      bus.host_req = 1; bus.host_we = 1; bus.host_addr = {10'd10, 10'd10}; bus.host_wdata = 2;
      @(negedge CLK);
      n_chk++;
      if ({bus.host_gnt, bus.ram_wren} !== 2'b11) begin
         n_fail++; $display("FAIL host_preload got gnt=%b wren=%b want 1 1", bus.host_gnt, bus.ram_wren);
      end
      bus.host_req = 0;
      @(negedge CLK);
      pix_valid = 1; VGA_X = 5; VGA_Y = 5;
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = {10'd10, 10'd10};
      repeat (3) begin
         @(negedge CLK);
         if (bus.host_gnt === 1'b1) seen++;
      end
      n_chk++;
      if (seen != 0) begin n_fail++; $display("FAIL host_rd_active got %0d grants want 0", seen); end
      pix_valid = 0;
      @(negedge CLK);
      n_chk++;
      if ({bus.host_gnt, bus.ram_rdaddress} !== {1'b1, 10'd10, 10'd10}) begin
         n_fail++; $display("FAIL host_rd_grant got gnt=%b rdaddr=%h want 1 %h",
                            bus.host_gnt, bus.ram_rdaddress, {10'd10, 10'd10});
      end
      bus.host_req = 0;
      @(negedge CLK);
      n_chk++;
      if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rd_early got rvalid=%b want 0", bus.host_rvalid); end
      @(negedge CLK);
      n_chk++;
      if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 2'd2}) begin
         n_fail++; $display("FAIL host_rd_data got rvalid=%b rdata=%0d want 1 2", bus.host_rvalid, bus.host_rdata);
      end
      @(negedge CLK);
      n_chk++;
      if (bus.host_rvalid !== 1'b0) begin n_fail++; $display("FAIL host_rvalid_pulse got %b want 0", bus.host_rvalid); end
      idle_inputs();
   endtask

   task automatic test_run_collision();
      int cnt, k, bad, gnts;
      cnt = 0; k = 0; bad = 0; gnts = 0;
      @(negedge CLK);
      pix_valid = 1; VGA_X = 100; VGA_Y = 50;
      run = 1;
      do begin
         @(negedge CLK);
         k++;
         if (busy === 1'b1) begin
            cnt++;
            if (bus.ram_wren !== 1'b1 || bus.ram_data !== 2'b00) bad++;
            if (bus.host_gnt === 1'b1) gnts++;
         end
         if (k == 1) run = 0;
         if (k == 2) begin
            run = 1; mark_en = 1; mark_val = 3;
            bus.host_req = 1; bus.host_we = 1; bus.host_addr = {10'd1, 10'd1}; bus.host_wdata = 3;
         end
      end while ((busy === 1'b1 || k < 2) && k < N + 100);
      n_chk++;
      if (cnt != N) begin n_fail++; $display("FAIL run_no_restart got %0d busy cycles want %0d", cnt, N); end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL clear_beats_mark got %0d bad writes want 0", bad); end
      n_chk++;
      if (gnts != 0) begin n_fail++; $display("FAIL host_in_clear got %0d grants want 0", gnts); end
      idle_inputs();
      repeat (3) @(negedge CLK);
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL run_idle_after got busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid_clear();
      int cnt;
      cnt = 0;
      @(negedge CLK) clear_req = 1;
      @(negedge CLK) clear_req = 0;
      while (busy === 1'b1 && cnt < 1000) begin
         cnt++;
         @(negedge CLK);
      end
      n_chk++;
      if (cnt != 1000 || busy !== 1'b1) begin
         n_fail++; $display("FAIL midclear_reach got %0d busy=%b want 1000 1", cnt, busy);
      end
      RESET_N = 0;
      #1;
      n_chk++;
      if ({busy, clear_done, bus.host_gnt, bus.host_rvalid, bus.host_rdata, bus.ram_rdaddress,
           bus.ram_wraddress, bus.ram_data, bus.ram_wren} !== 49'h0) begin
         n_fail++; $display("FAIL midclear_reset got busy=%b wren=%b wraddr=%h want all 0",
                            busy, bus.ram_wren, bus.ram_wraddress);
      end
      @(negedge CLK) RESET_N = 1;
      repeat (3) @(negedge CLK);
      n_chk++;
      if ({busy, bus.ram_wren} !== 2'b00) begin
         n_fail++; $display("FAIL post_reset_idle got busy=%b wren=%b want 0 0", busy, bus.ram_wren);
      end
      clear_req = 1;
      @(negedge CLK) clear_req = 0;
      @(negedge CLK);
      n_chk++;
      if ({busy, bus.ram_wraddress} !== {1'b1, 10'd0, 10'd1}) begin
         n_fail++; $display("FAIL sweep_restart got busy=%b addr=%h want 1 %h",
                            busy, bus.ram_wraddress, {10'd0, 10'd1});
      end
      RESET_N = 0;
      @(negedge CLK) RESET_N = 1;
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_clear_sweep();
      test_mark_lag();
      test_host_active();
      test_host_read();
      test_run_collision();
      test_reset_mid_clear();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
